// File: rtl/cv_tile_scheduler_pkg.sv
// Shared types for the conv-layer tile scheduler: field width, FSM states, loader commands.
package cv_tile_scheduler_pkg;

  localparam int unsigned DIM_W = 11;

  typedef logic [DIM_W-1:0] dim_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LW,
    S_LIF,
    S_SOF,
    S_NEXT,
    S_FIN
  } state_e;

  typedef enum logic [1:0] {
    CMD_LW,
    CMD_LIF,
    CMD_SOF
  } cmd_e;

  // Command register layout: bit0 load_weight, bit1 load_input, bit2 store_output.
  function automatic logic [2:0] cmd_onehot(input cmd_e c);
    case (c)
      CMD_LW:  cmd_onehot = 3'b001;
      CMD_LIF: cmd_onehot = 3'b010;
      CMD_SOF: cmd_onehot = 3'b100;
      default: cmd_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cv_tile_scheduler_if.sv
// Scheduler-to-loader command bus: command levels, per-tile fields and the loader's done pulse.
interface cv_tile_scheduler_if;
  import cv_tile_scheduler_pkg::*;

  logic load_weight;
  logic load_input;
  logic store_output;
  logic ld_done;
  dim_t Iori, Oori, Hori, Wori;
  dim_t Iext, Oext, Hext, Wext;

  modport master (
    output load_weight, load_input, store_output,
    output Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
    input  ld_done
  );

  modport slave (
    input  load_weight, load_input, store_output,
    input  Iori, Oori, Hori, Wori, Iext, Oext, Hext, Wext,
    output ld_done
  );
endinterface

// File: rtl/cv_tile_scheduler_extent.sv
// Tile extent along one axis: min(TILE, total - origin) plus a kernel halo term.
module cv_tile_extent
  import cv_tile_scheduler_pkg::*;
#(
  parameter int unsigned TILE = 8
) (
  input  logic signed [DIM_W:0] total,
  input  dim_t                  origin,
  input  dim_t                  add,
  output dim_t                  ext
);
  localparam logic signed [DIM_W+1:0] TILE_S = (DIM_W+2)'(TILE);

  logic signed [DIM_W+1:0] rem;

  always_comb begin
    rem = $signed({total[DIM_W], total}) - $signed({2'b00, origin});
    if (rem < TILE_S) ext = DIM_W'(rem) + add;
    else              ext = DIM_W'(TILE) + add;
  end
endmodule

// File: rtl/cv_tile_scheduler.sv
// Walks one conv layer in output tiles (o outer, h, w inner) and issues
// load_weight / load_input / store_output commands with registered tile fields.
module cv_tile_scheduler
  import cv_tile_scheduler_pkg::*;
#(
  parameter int unsigned TILE_O = 8,
  parameter int unsigned TILE_H = 8,
  parameter int unsigned TILE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  dim_t       I,
  input  dim_t       O,
  input  dim_t       H,
  input  dim_t       W,
  input  logic [4:0] K,
  input  logic [1:0] pad,
  output logic       busy,
  output logic       layer_done,
  cv_tile_scheduler_if.master ld
);
  localparam int unsigned SW = DIM_W + 1;
  localparam int unsigned CW = DIM_W + 2;

  state_e     state_q, state_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [2:0] cmd_q, cmd_d;
  dim_t       idim_q, idim_d, odim_q, odim_d, hdim_q, hdim_d, wdim_q, wdim_d;
  logic [4:0] k_q, k_d;
  logic [1:0] pad_q, pad_d;
  dim_t       oc_q, oc_d, hc_q, hc_d, wc_q, wc_d;
  dim_t       oori_q, oori_d, hori_q, hori_d, wori_q, wori_d;
  dim_t       iext_q, iext_d, oext_q, oext_d, hext_q, hext_d, wext_q, wext_d;
  logic       load_fields;

  logic signed [SW-1:0] hp, wp;
  logic [CW-1:0]        o_inc, h_inc, w_inc;
  logic                 wrap_w, wrap_h, o_last;
  dim_t                 km1, oext_w, hext_w, wext_w;

  always_comb begin
    hp = $signed({1'b0, hdim_q} + {{(SW-3){1'b0}}, pad_q, 1'b0} - {{(SW-5){1'b0}}, k_q} + SW'(1));
    wp = $signed({1'b0, wdim_q} + {{(SW-3){1'b0}}, pad_q, 1'b0} - {{(SW-5){1'b0}}, k_q} + SW'(1));
    km1    = {{(DIM_W-5){1'b0}}, k_q} - dim_t'(1);
    o_inc  = {2'b00, oc_q} + CW'(TILE_O);
    h_inc  = {2'b00, hc_q} + CW'(TILE_H);
    w_inc  = {2'b00, wc_q} + CW'(TILE_W);
    wrap_w = $signed(w_inc) >= $signed({wp[SW-1], wp});
    wrap_h = $signed(h_inc) >= $signed({hp[SW-1], hp});
    o_last = o_inc >= {2'b00, odim_q};
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_d       = cmd_q;
    idim_d      = idim_q;
    odim_d      = odim_q;
    hdim_d      = hdim_q;
    wdim_d      = wdim_q;
    k_d         = k_q;
    pad_d       = pad_q;
    oc_d        = oc_q;
    hc_d        = hc_q;
    wc_d        = wc_q;
    load_fields = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        idim_d  = I;
        odim_d  = O;
        hdim_d  = H;
        wdim_d  = W;
        k_d     = K;
        pad_d   = pad;
        busy_d  = 1'b1;
        state_d = S_CFG;
      end
      S_CFG: begin
        oc_d = '0;
        hc_d = '0;
        wc_d = '0;
        if (hp <= 0 || wp <= 0 || odim_q == '0 || idim_q == '0) begin
          state_d = S_FIN;
          done_d  = 1'b1;
        end else begin
          state_d     = S_LW;
          cmd_d       = cmd_onehot(CMD_LW);
          load_fields = 1'b1;
        end
      end
      S_LW: if (ld.ld_done) begin
        state_d = S_LIF;
        cmd_d   = cmd_onehot(CMD_LIF);
      end
      S_LIF: if (ld.ld_done) begin
        state_d = S_SOF;
        cmd_d   = cmd_onehot(CMD_SOF);
      end
      S_SOF: if (ld.ld_done) begin
        state_d = S_NEXT;
        cmd_d   = '0;
      end
      S_NEXT: begin
        if (!wrap_w) begin
          wc_d        = dim_t'(w_inc);
          state_d     = S_LIF;
          cmd_d       = cmd_onehot(CMD_LIF);
          load_fields = 1'b1;
        end else begin
          wc_d = '0;
          if (!wrap_h) begin
            hc_d        = dim_t'(h_inc);
            state_d     = S_LIF;
            cmd_d       = cmd_onehot(CMD_LIF);
            load_fields = 1'b1;
          end else begin
            hc_d = '0;
            if (o_last) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              oc_d        = dim_t'(o_inc);
              state_d     = S_LW;
              cmd_d       = cmd_onehot(CMD_LW);
              load_fields = 1'b1;
            end
          end
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Extents see the next-tile origins so fields land together with the command edge.
  cv_tile_extent #(.TILE(TILE_O)) u_ext_o (.total({1'b0, odim_q}), .origin(oc_d), .add('0), .ext(oext_w));
  cv_tile_extent #(.TILE(TILE_H)) u_ext_h (.total(hp), .origin(hc_d), .add(km1), .ext(hext_w));
  cv_tile_extent #(.TILE(TILE_W)) u_ext_w (.total(wp), .origin(wc_d), .add(km1), .ext(wext_w));

  always_comb begin
    oori_d = oori_q;
    hori_d = hori_q;
    wori_d = wori_q;
    iext_d = iext_q;
    oext_d = oext_q;
    hext_d = hext_q;
    wext_d = wext_q;
    if (load_fields) begin
      oori_d = oc_d;
      hori_d = hc_d - dim_t'(pad_q);
      wori_d = wc_d - dim_t'(pad_q);
      iext_d = idim_q;
      oext_d = oext_w;
      hext_d = hext_w;
      wext_d = wext_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cmd_q   <= '0;
      idim_q  <= '0;
      odim_q  <= '0;
      hdim_q  <= '0;
      wdim_q  <= '0;
      k_q     <= '0;
      pad_q   <= '0;
      oc_q    <= '0;
      hc_q    <= '0;
      wc_q    <= '0;
      oori_q  <= '0;
      hori_q  <= '0;
      wori_q  <= '0;
      iext_q  <= '0;
      oext_q  <= '0;
      hext_q  <= '0;
      wext_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      idim_q  <= idim_d;
      odim_q  <= odim_d;
      hdim_q  <= hdim_d;
      wdim_q  <= wdim_d;
      k_q     <= k_d;
      pad_q   <= pad_d;
      oc_q    <= oc_d;
      hc_q    <= hc_d;
      wc_q    <= wc_d;
      oori_q  <= oori_d;
      hori_q  <= hori_d;
      wori_q  <= wori_d;
      iext_q  <= iext_d;
      oext_q  <= oext_d;
      hext_q  <= hext_d;
      wext_q  <= wext_d;
    end
  end

  assign busy            = busy_q;
  assign layer_done      = done_q;
  assign ld.load_weight  = cmd_q[0];
  assign ld.load_input   = cmd_q[1];
  assign ld.store_output = cmd_q[2];
  assign ld.Iori         = '0;
  assign ld.Oori         = oori_q;
  assign ld.Hori         = hori_q;
  assign ld.Wori         = wori_q;
  assign ld.Iext         = iext_q;
  assign ld.Oext         = oext_q;
  assign ld.Hext         = hext_q;
  assign ld.Wext         = wext_q;
endmodule

// File: tb/tb_cv_tile_scheduler.sv
// Bench for cv_tile_scheduler: loop-nest reference model, randomized loader latency and layers.
module tb_cv_tile_scheduler;
  import cv_tile_scheduler_pkg::*;

  localparam int unsigned TO = 4;
  localparam int unsigned TH = 4;
  localparam int unsigned TW = 4;

  typedef struct {
    int kind;
    int oori, hori, wori, iext, oext, hext, wext;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  dim_t       I_i, O_i, H_i, W_i;
  logic [4:0] K_i;
  logic [1:0] pad_i;
  logic       busy, layer_done;
  logic       ld_done_drv = 1'b0;

  cv_tile_scheduler_if ldif ();
  assign ldif.ld_done = ld_done_drv;

  cv_tile_scheduler #(.TILE_O(TO), .TILE_H(TH), .TILE_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .I(I_i), .O(O_i), .H(H_i), .W(W_i), .K(K_i), .pad(pad_i),
    .busy(busy), .layer_done(layer_done), .ld(ldif)
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0, cyc = 0;
  cmd_t exp_q[$];
  cmd_t cur_e;
  bit   chk_en = 1'b0, done_seen = 1'b0, spur_en = 1'b0, has_cmds;
  int   n_done = 0, first_cmd_cyc = -1, done_cyc = 0, ld_cyc = 0, start_cyc = 0;
  int   cnt = -1, fix_dly = -1, max_dly = 3;
  logic [2:0]  prev_c = 3'b000, cvec;
  logic [87:0] cap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [87:0] fields();
    return {ldif.Iori, ldif.Oori, ldif.Hori, ldif.Wori, ldif.Iext, ldif.Oext, ldif.Hext, ldif.Wext};
  endfunction

  // Expected command stream for one layer, straight from the loop-nest description.
  function automatic void build(input int i, input int o, input int k, input int h, input int w, input int p);
    int   hp, wp;
    cmd_t m;
    hp = h + 2 * p - k + 1;
    wp = w + 2 * p - k + 1;
    exp_q.delete();
    if (hp <= 0 || wp <= 0 || o == 0 || i == 0) return;
    for (int oo = 0; oo < o; oo += TO) begin
      m = '{kind: 0, oori: oo, hori: 0, wori: 0, iext: i, oext: imin(int'(TO), o - oo), hext: 0, wext: 0};
      exp_q.push_back(m);
      for (int hh = 0; hh < hp; hh += TH) begin
        for (int ww = 0; ww < wp; ww += TW) begin
          m.kind = 1;
          m.hori = (hh - p) & 'h7FF;
          m.wori = (ww - p) & 'h7FF;
          m.hext = imin(int'(TH), hp - hh) + k - 1;
          m.wext = imin(int'(TW), wp - ww) + k - 1;
          exp_q.push_back(m);
          m.kind = 2;
          exp_q.push_back(m);
        end
      end
    end
  endfunction

  // Compare first, then act as the loader, all on the falling edge.
  always @(negedge clk) begin
    cvec = {ldif.store_output, ldif.load_input, ldif.load_weight};
    if (chk_en) begin
      if (cvec != 3'b000) begin
        check("cmd_onehot", $countones(cvec), 1);
        check("busy_during_cmd", busy, 1'b1);
        if (cvec != prev_c || ld_done_drv) begin
          if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
          if (exp_q.size() == 0) check("unexpected_cmd", cvec, 3'b000);
          else begin
            cur_e = exp_q.pop_front();
            check("cmd_kind", cvec, 1 << cur_e.kind);
            check("Iori", ldif.Iori, 0);
            check("Oori", ldif.Oori, cur_e.oori);
            check("Iext", ldif.Iext, cur_e.iext);
            check("Oext", ldif.Oext, cur_e.oext);
            if (cur_e.kind != 0) begin
              check("Hori", ldif.Hori, cur_e.hori);
              check("Wori", ldif.Wori, cur_e.wori);
              check("Hext", ldif.Hext, cur_e.hext);
              check("Wext", ldif.Wext, cur_e.wext);
            end
          end
          cap = fields();
        end else check("fields_stable", fields(), cap);
      end
      if (layer_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        n_done++;
        check("done_queue_empty", exp_q.size(), 0);
        check("busy_at_done", busy, 1'b1);
      end
    end
    prev_c = cvec;
    if (ld_done_drv) begin
      ld_done_drv = 1'b0;
      cnt = -1;
    end else if (cvec != 3'b000) begin
      if (cnt < 0) cnt = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, max_dly));
      if (cnt == 0) begin
        ld_done_drv = 1'b1;
        ld_cyc = cyc;
        cnt = -1;
      end else cnt--;
    end else if (spur_en && $urandom_range(0, 3) == 0) ld_done_drv = 1'b1;
  end

  task automatic set_params(input int i, input int o, input int k, input int h, input int w, input int p);
    I_i = dim_t'(i); O_i = dim_t'(o); K_i = 5'(k); H_i = dim_t'(h); W_i = dim_t'(w); pad_i = 2'(p);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    done_seen = 1'b0;
    first_cmd_cyc = -1;
    n_done = 0;
    @(posedge clk); #1;
    start = 1'b0;
    set_params($urandom_range(1, 2000), $urandom_range(1, 2000), $urandom_range(1, 31),
               $urandom_range(1, 2000), $urandom_range(1, 2000), $urandom_range(0, 3));
  endtask

  task automatic run_layer(input int i, input int o, input int k, input int h, input int w, input int p,
                           input bit mid_start, input bit coinc);
    build(i, o, k, h, w, p);
    has_cmds = (exp_q.size() > 0);
    set_params(i, o, k, h, w, p);
    pulse_start();
    if (coinc) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    if (mid_start) begin
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int n = 0; n < 30000 && !done_seen; n++) @(posedge clk);
    if (!done_seen) check("layer_done_timeout", 0, 1);
    else if (has_cmds) begin
      check("first_cmd_latency", first_cmd_cyc - start_cyc, 2);
      check("done_after_last_ld", done_cyc - ld_cyc, 2);
    end else check("degen_done_latency", done_cyc - start_cyc, 2);
    @(negedge clk);
    check("busy_low_after_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("single_done_pulse", n_done, 1);
    check("idle_no_cmd", {ldif.store_output, ldif.load_input, ldif.load_weight}, 3'b000);
    check("busy_stays_low", busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    set_params(0, 0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, layer_done, ldif.store_output, ldif.load_input, ldif.load_weight, fields()}, '0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    build(3, 8, 3, 8, 8, 1);
    check("model1_len", exp_q.size(), 18);
    check("model1_lif_hori", exp_q[1].hori, 'h7FF);
    check("model1_lif_wori", exp_q[1].wori, 'h7FF);
    check("model1_lif_hext", exp_q[1].hext, 6);
    check("model1_lif_iext", exp_q[1].iext, 3);
    check("model1_lif_oext", exp_q[1].oext, 4);
    check("model1_lw2_oori", exp_q[9].oori, 4);
    build(1, 5, 3, 7, 7, 0);
    check("model2_len", exp_q.size(), 18);
    check("model2_edge_hori", exp_q[5].hori, 4);
    check("model2_edge_hext", exp_q[5].hext, 3);
    check("model2_last_lw_oext", exp_q[9].oext, 1);
    build(1, 4, 1, 4, 4, 0);
    check("model6_len", exp_q.size(), 3);
    check("model6_hext_wext_oext", {exp_q[1].hext, exp_q[1].wext, exp_q[1].oext}, {32'd4, 32'd4, 32'd4});
    exp_q.delete();

    run_layer(3, 8, 3, 8, 8, 1, 1'b0, 1'b0);
    run_layer(1, 5, 3, 7, 7, 0, 1'b0, 1'b0);
    run_layer(1, 4, 1, 4, 4, 0, 1'b0, 1'b0);
    run_layer(2, 3, 5, 3, 3, 0, 1'b0, 1'b1);

    fix_dly = 50;
    run_layer(3, 8, 3, 8, 8, 1, 1'b1, 1'b0);
    fix_dly = -1;

    spur_en = 1'b1;
    for (int t = 0; t < 6; t++)
      run_layer($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(1, 5),
                $urandom_range(1, 18), $urandom_range(1, 18), $urandom_range(0, 3), 1'b0, 1'b0);
    spur_en = 1'b0;

    build(3, 8, 3, 8, 8, 1);
    set_params(3, 8, 3, 8, 8, 1);
    pulse_start();
    for (int n = 0; n < 2000 && !ldif.load_input; n++) @(negedge clk);
    check("reached_lif", ldif.load_input, 1'b1);
    rst_n  = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
    check("reset_mid_lif", {busy, layer_done, ldif.store_output, ldif.load_input, ldif.load_weight, fields()}, '0);
    ld_done_drv = 1'b0;
    cnt = -1;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    run_layer(3, 8, 3, 8, 8, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
